// File: rtl/mul_seq_pkg.sv
// Shared constants, op encoding and FSM states for the RV32M multiply sequencer.
// pp_align places a 16x16 partial product at its weight in the 64-bit sum.
package mul_seq_pkg;

  localparam int XLEN = 32;
  localparam int HALF = 16;

  localparam logic [1:0] OP_MUL    = 2'b00;
  localparam logic [1:0] OP_MULH   = 2'b01;
  localparam logic [1:0] OP_MULHSU = 2'b10;
  localparam logic [1:0] OP_MULHU  = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_ACC,
    S_FIX,
    S_RESP
  } state_t;

  // idx: 0 lo*lo, 1 lo*hi, 2 hi*lo, 3 hi*hi
  function automatic logic [2*XLEN-1:0] pp_align(input logic [XLEN-1:0] pp,
                                                 input logic [1:0]      idx);
    logic [2*XLEN-1:0] w_ext;
    w_ext = {{XLEN{1'b0}}, pp};
    case (idx)
      2'd0:    return w_ext;
      2'd3:    return w_ext << XLEN;
      default: return w_ext << HALF;
    endcase
  endfunction

endpackage

// File: rtl/mul_sign_mag.sv
// Two's-complement magnitude and sign of one operand; 0x80000000 maps to itself.
module mul_sign_mag
  import mul_seq_pkg::*;
(
  input  logic [XLEN-1:0] i_val,
  input  logic            i_signed,
  output logic [XLEN-1:0] o_mag,
  output logic            o_neg
);

  assign o_neg = i_signed & i_val[XLEN-1];
  assign o_mag = o_neg ? (~i_val + {{(XLEN-1){1'b0}}, 1'b1}) : i_val;

endmodule

// File: rtl/mul32_sequencer.sv
// Runs MUL/MULH/MULHSU/MULHU on an external 16x16 shift-add multiplier by issuing
// partial products of the operand magnitudes and sign-fixing the 64-bit sum.
module mul32_sequencer
  import mul_seq_pkg::*;
#(
  parameter bit SKIP_HH    = 1'b1,
  parameter bit EARLY_ZERO = 1'b1
) (
  input  logic            Clk,
  input  logic            Rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [1:0]      req_op,
  input  logic [XLEN-1:0] req_a,
  input  logic [XLEN-1:0] req_b,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [XLEN-1:0] rsp_data,
  output logic            busy,
  output logic [HALF-1:0] mul_a,
  output logic [HALF-1:0] mul_b,
  output logic            mul_st,
  input  logic [XLEN-1:0] mul_p,
  input  logic            mul_idle,
  input  logic            mul_done
);

  state_t            r_state, w_next;
  logic [1:0]        r_op;
  logic [XLEN-1:0]   r_mag_a, r_mag_b;
  logic              r_neg, r_zero;
  logic [1:0]        r_idx;
  logic [2*XLEN-1:0] r_acc;
  logic [XLEN-1:0]   r_pp;
  logic [HALF-1:0]   r_mul_a, r_mul_b;
  logic              r_mul_st;
  logic [XLEN-1:0]   r_rsp_data;

  logic              w_sgn_a, w_sgn_b;
  logic [XLEN-1:0]   w_mag_a, w_mag_b;
  logic              w_neg_a, w_neg_b;
  logic              w_zero, w_last, w_cap;
  logic [HALF-1:0]   w_half_a, w_half_b;
  logic [2*XLEN-1:0] w_res;

  assign w_sgn_a = (req_op == OP_MULH) || (req_op == OP_MULHSU);
  assign w_sgn_b = (req_op == OP_MULH);

  mul_sign_mag u_sm_a (
    .i_val    (req_a),
    .i_signed (w_sgn_a),
    .o_mag    (w_mag_a),
    .o_neg    (w_neg_a)
  );

  mul_sign_mag u_sm_b (
    .i_val    (req_b),
    .i_signed (w_sgn_b),
    .o_mag    (w_mag_b),
    .o_neg    (w_neg_b)
  );

  assign w_zero   = EARLY_ZERO && ((req_a == '0) || (req_b == '0));
  assign w_last   = (r_idx == 2'd3) || (SKIP_HH && (r_op == OP_MUL) && (r_idx == 2'd2));
  // Done seen during the St cycle is a leftover level from the previous product.
  assign w_cap    = mul_done && !r_mul_st;
  assign w_half_a = r_idx[1] ? r_mag_a[XLEN-1:HALF] : r_mag_a[HALF-1:0];
  assign w_half_b = r_idx[0] ? r_mag_b[XLEN-1:HALF] : r_mag_b[HALF-1:0];
  assign w_res    = r_neg ? (~r_acc + 64'd1) : r_acc;

  always_ff @(posedge Clk) begin
    if (Rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    busy      = 1'b1;
    case (r_state)
      S_IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
        if (req_valid) w_next = S_ISSUE;
      end
      S_ISSUE: begin
        // zero bypass still spends one cycle here so the response lands two edges out
        if (r_zero)        w_next = S_FIX;
        else if (mul_idle) w_next = S_WAIT;
      end
      S_WAIT:  if (w_cap) w_next = S_ACC;
      S_ACC:   w_next = w_last ? S_FIX : S_ISSUE;
      S_FIX:   w_next = S_RESP;
      S_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_op       <= OP_MUL;
      r_mag_a    <= '0;
      r_mag_b    <= '0;
      r_neg      <= 1'b0;
      r_zero     <= 1'b0;
      r_idx      <= '0;
      r_acc      <= '0;
      r_pp       <= '0;
      r_mul_a    <= '0;
      r_mul_b    <= '0;
      r_mul_st   <= 1'b0;
      r_rsp_data <= '0;
    end else begin
      r_mul_st <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_op    <= req_op;
            r_mag_a <= w_mag_a;
            r_mag_b <= w_mag_b;
            r_neg   <= w_neg_a ^ w_neg_b;
            r_zero  <= w_zero;
            r_idx   <= '0;
            r_acc   <= '0;
          end
        end
        S_ISSUE: begin
          if (!r_zero && mul_idle) begin
            r_mul_a  <= w_half_a;
            r_mul_b  <= w_half_b;
            r_mul_st <= 1'b1;
          end
        end
        S_WAIT: if (w_cap) r_pp <= mul_p;
        S_ACC: begin
          r_acc <= r_acc + pp_align(r_pp, r_idx);
          if (!w_last) r_idx <= r_idx + 2'd1;
        end
        S_FIX: r_rsp_data <= (r_op == OP_MUL) ? w_res[XLEN-1:0] : w_res[2*XLEN-1:XLEN];
        default: ;
      endcase
    end
  end

  assign mul_a    = r_mul_a;
  assign mul_b    = r_mul_b;
  assign mul_st   = r_mul_st;
  assign rsp_data = r_rsp_data;

endmodule

// File: tb/tb_mul32_sequencer.sv
// Directed and random checks of mul32_sequencer against 64-bit reference arithmetic,
// with a behavioural 16x16 multiplier of variable latency attached.
module tb_mul32_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_op = 2'b00;
  logic [31:0] req_a = '0, req_b = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_data;
  logic        busy;
  logic [15:0] mul_a, mul_b;
  logic        mul_st;
  logic [31:0] mul_p;
  logic        mul_idle, mul_done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mul32_sequencer #(.SKIP_HH(1'b1), .EARLY_ZERO(1'b1)) dut (
    .Clk(clk), .Rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .busy(busy),
    .mul_a(mul_a), .mul_b(mul_b), .mul_st(mul_st),
    .mul_p(mul_p), .mul_idle(mul_idle), .mul_done(mul_done)
  );

  // Multiplier model: Done stays high as a stale level until the next St.
  int          m_lat = 2;
  int          m_cnt;
  logic [15:0] m_a, m_b;
  always @(posedge clk) begin
    if (rst) begin
      mul_idle <= 1'b1; mul_done <= 1'b0; mul_p <= '0; m_cnt <= 0; m_a <= '0; m_b <= '0;
    end else if (mul_st && mul_idle) begin
      mul_idle <= 1'b0; mul_done <= 1'b0; m_a <= mul_a; m_b <= mul_b; m_cnt <= m_lat;
    end else if (!mul_idle && !mul_done) begin
      if (m_cnt == 0) begin
        mul_done <= 1'b1;
        mul_p    <= {16'h0, m_a} * {16'h0, m_b};
      end else m_cnt <= m_cnt - 1;
    end else if (!mul_idle && mul_done) mul_idle <= 1'b1;
  end

  int   st_cnt = 0;
  int   st_dbl = 0;
  logic st_prev = 1'b0;
  always @(posedge clk) begin
    if (mul_st) st_cnt <= st_cnt + 1;
    if (mul_st && st_prev) st_dbl <= st_dbl + 1;
    st_prev <= mul_st;
  end

  function automatic logic [31:0] ref_mul(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [63:0] xa, xb, p;
    xa = (op == 2'b01 || op == 2'b10) ? {{32{a[31]}}, a} : {32'h0, a};
    xb = (op == 2'b01) ? {{32{b[31]}}, b} : {32'h0, b};
    p  = xa * xb;
    return (op == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    int n = 0;
    req_op = op; req_a = a; req_b = b; req_valid = 1'b1;
    while (!req_ready && n < 50) begin tick(); n++; end
    chk("issue_ready", req_ready, 1);
    tick();
    req_valid = 1'b0;
    req_a = $urandom; req_b = $urandom; req_op = 2'($urandom);
  endtask

  task automatic wait_rsp();
    int n = 0;
    while (!rsp_valid && n < 400) begin tick(); n++; end
    chk("rsp_timeout", rsp_valid, 1);
  endtask

  task automatic handshake();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("post_hs_valid", rsp_valid, 0);
    chk("post_hs_ready", req_ready, 1);
  endtask

  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int pulses);
    int st0;
    st0 = st_cnt;
    issue(op, a, b);
    wait_rsp();
    chk({tag, "_data"}, rsp_data, exp);
    chk({tag, "_pulses"}, st_cnt - st0, pulses);
    chk({tag, "_busy"}, {busy, req_ready}, 2'b10);
    handshake();
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_ready"}, req_ready, 1);
    chk({tag, "_valid"}, rsp_valid, 0);
    chk({tag, "_data"}, rsp_data, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_st"}, mul_st, 0);
    chk({tag, "_mab"}, {mul_a, mul_b}, 0);
  endtask

  initial begin
    int st0, n;
    logic [1:0]  op;
    logic [31:0] a, b, a2, b2;

    repeat (3) tick();
    rst = 1'b0;
    chk_reset_outs("reset");

    run_op("mul_5x3",    2'b00, 32'd5, 32'd3, 32'h0000000F, 3);
    run_op("mulhu_ff",   2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 4);
    run_op("mul_ff",     2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 3);
    m_lat = 0;
    run_op("mulh_min",   2'b01, 32'h80000000, 32'h80000000, 32'h40000000, 4);
    m_lat = 4;
    run_op("mulh_m1x1",  2'b01, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFF, 4);
    run_op("mulhsu_ff",  2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 4);

    // zero bypass: valid two edges after the accept edge, no St
    st0 = st_cnt;
    req_op = 2'b00; req_a = 32'h0; req_b = 32'h1234; req_valid = 1'b1;
    chk("ez_ready", req_ready, 1);
    tick();
    req_valid = 1'b0;
    chk("ez_e0", rsp_valid, 0);
    tick();
    chk("ez_e1", rsp_valid, 0);
    tick();
    chk("ez_e2", rsp_valid, 1);
    chk("ez_data", rsp_data, 0);
    chk("ez_pulses", st_cnt - st0, 0);
    handshake();

    // backpressure with a second request offered during the stall
    m_lat = 1;
    issue(2'b00, 32'd1000, 32'd50);
    wait_rsp();
    a2 = $urandom; b2 = $urandom;
    req_op = 2'b11; req_a = a2; req_b = b2; req_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      chk("bp_data", rsp_data, 32'h0000C350);
      chk("bp_ready", req_ready, 0);
      chk("bp_valid", rsp_valid, 1);
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("bp_idle_ready", req_ready, 1);
    tick();
    req_valid = 1'b0;
    req_a = $urandom; req_b = $urandom;
    chk("bp_second_busy", busy, 1);
    wait_rsp();
    chk("bp_second_data", rsp_data, ref_mul(2'b11, a2, b2));
    handshake();

    // reset while waiting on the multiplier
    m_lat = 3;
    issue(2'b11, 32'hDEADBEEF, 32'h12345678);
    n = 0;
    while (!mul_st && n < 50) begin tick(); n++; end
    chk("rst_reach_wait", mul_st, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_reset_outs("midrst");
    run_op("mul_10x4", 2'b00, 32'd10, 32'd4, 32'h00000028, 3);

    for (int i = 0; i < 24; i++) begin
      op = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 5))
        0:       a = 32'h80000000;
        1:       a = 32'hFFFFFFFF;
        2:       a = 32'h0;
        default: a = $urandom;
      endcase
      b = ($urandom_range(0, 4) == 0) ? 32'($urandom_range(0, 2)) : $urandom;
      m_lat = $urandom_range(0, 4);
      run_op("rand", op, a, b, ref_mul(op, a, b),
             (a == 0 || b == 0) ? 0 : ((op == 2'b00) ? 3 : 4));
    end

    chk("st_single_cycle", st_dbl, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
